// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encodings, the
// per-stage control bundle and the load-use match helper.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MUL_WAIT = 2'd2
    } hz_state_e;

    // Operand-source selects understood by the forwarding unit next door.
    typedef enum logic [1:0] {
        FWD_NONE   = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_DEFAULT  = 8'b1111_0000;
    localparam hz_ctrl_t CTRL_FREEZE   = 8'b0000_0001;
    localparam hz_ctrl_t CTRL_FLUSH    = 8'b1111_1110;
    localparam hz_ctrl_t CTRL_MUL_HOLD = 8'b0001_0010;
    localparam hz_ctrl_t CTRL_LOAD_USE = 8'b0011_0100;

    // r0 is hardwired, so a load targeting it can never create a dependency.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt
    );
        return mem_read && (ex_rt != ZERO_REG) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: decides each cycle which
// pipeline registers load, hold, bubble or flush, and keeps hazard statistics.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_Rs_i,
    input  logic [4:0]       IF_ID_Rt_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_Rt_i,
    input  logic             branch_taken_i,
    input  logic             mul_start_i,
    input  logic             mul_done_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             ID_EX_write_o,
    output logic             EX_MEM_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_bubble_o,
    output logic             EX_MEM_bubble_o,
    output logic             MEM_WB_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_err_o
);

    localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic             mem_err_q;
    logic             mem_err_d;
    hz_ctrl_t         ctrl;
    logic             flush_evt;
    logic             stall_evt;
    logic             mem_stall;
    logic             mul_stall;
    logic             load_use;

    assign mem_stall = dmem_req_i & ~dmem_ready_i;
    assign mul_stall = mul_start_i & ~mul_done_i;
    assign load_use  = load_use_hit(ID_EX_MemRead_i, ID_EX_Rt_i, IF_ID_Rs_i, IF_ID_Rt_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_err_d = mem_err_q;
        ctrl      = CTRL_DEFAULT;
        flush_evt = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                    tmo_d   = '0;
                end else if (branch_taken_i) begin
                    // Younger mul/load-use hazards are being squashed, so they lose.
                    ctrl      = CTRL_FLUSH;
                    flush_evt = 1'b1;
                end else if (mul_stall) begin
                    ctrl    = CTRL_MUL_HOLD;
                    state_d = ST_MUL_WAIT;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end

            ST_MEM_WAIT: begin
                // A branch sitting in the frozen EX/MEM is picked up again once back in RUN.
                if (dmem_ready_i) begin
                    state_d = ST_RUN;
                end else if (tmo_q == TMO_LAST) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    ctrl  = CTRL_FREEZE;
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_MUL_WAIT: begin
                if (mem_stall) begin
                    ctrl = CTRL_FREEZE;
                end else if (mul_done_i) begin
                    state_d = ST_RUN;
                end else begin
                    ctrl = CTRL_MUL_HOLD;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The pipeline must free-run while held in reset.
        if (!rst_i) begin
            ctrl      = CTRL_DEFAULT;
            flush_evt = 1'b0;
        end
    end

    assign stall_evt = ~ctrl.pc_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_evt),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_evt),
        .cnt_o (flush_cnt_o)
    );

    assign PC_write_o      = ctrl.pc_write;
    assign IF_ID_write_o   = ctrl.if_id_write;
    assign ID_EX_write_o   = ctrl.id_ex_write;
    assign EX_MEM_write_o  = ctrl.ex_mem_write;
    assign IF_ID_flush_o   = ctrl.if_id_flush;
    assign ID_EX_bubble_o  = ctrl.id_ex_bubble;
    assign EX_MEM_bubble_o = ctrl.ex_mem_bubble;
    assign MEM_WB_bubble_o = ctrl.mem_wb_bubble;
    assign state_o         = state_q;
    assign mem_err_o       = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues the
// expected control vector and state, the negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] E_DEF = 8'b1111_0000;
    localparam logic [7:0] E_FRZ = 8'b0000_0001;
    localparam logic [7:0] E_BR  = 8'b1111_1110;
    localparam logic [7:0] E_MH  = 8'b0001_0010;
    localparam logic [7:0] E_LU  = 8'b0011_0100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  IF_ID_Rs_i;
    logic [4:0]  IF_ID_Rt_i;
    logic        ID_EX_MemRead_i;
    logic [4:0]  ID_EX_Rt_i;
    logic        branch_taken_i;
    logic        mul_start_i;
    logic        mul_done_i;
    logic        dmem_req_i;
    logic        dmem_ready_i;
    logic        PC_write_o;
    logic        IF_ID_write_o;
    logic        ID_EX_write_o;
    logic        EX_MEM_write_o;
    logic        IF_ID_flush_o;
    logic        ID_EX_bubble_o;
    logic        EX_MEM_bubble_o;
    logic        MEM_WB_bubble_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    logic        mem_err_o;

    pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .IF_ID_Rs_i      (IF_ID_Rs_i),
        .IF_ID_Rt_i      (IF_ID_Rt_i),
        .ID_EX_MemRead_i (ID_EX_MemRead_i),
        .ID_EX_Rt_i      (ID_EX_Rt_i),
        .branch_taken_i  (branch_taken_i),
        .mul_start_i     (mul_start_i),
        .mul_done_i      (mul_done_i),
        .dmem_req_i      (dmem_req_i),
        .dmem_ready_i    (dmem_ready_i),
        .PC_write_o      (PC_write_o),
        .IF_ID_write_o   (IF_ID_write_o),
        .ID_EX_write_o   (ID_EX_write_o),
        .EX_MEM_write_o  (EX_MEM_write_o),
        .IF_ID_flush_o   (IF_ID_flush_o),
        .ID_EX_bubble_o  (ID_EX_bubble_o),
        .EX_MEM_bubble_o (EX_MEM_bubble_o),
        .MEM_WB_bubble_o (MEM_WB_bubble_o),
        .state_o         (state_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o),
        .mem_err_o       (mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      tag;
        logic [7:0] ctl;
        logic [1:0] st;
    } sb_item_t;

    sb_item_t   sb_q[$];
    sb_item_t   sb_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ctl_obs;

    assign ctl_obs = {PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o,
                      IF_ID_flush_o, ID_EX_bubble_o, EX_MEM_bubble_o, MEM_WB_bubble_o};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb_q.size() != 0) begin
            sb_e = sb_q.pop_front();
            check_eq({sb_e.tag, "/ctl"},   32'(ctl_obs), 32'(sb_e.ctl));
            check_eq({sb_e.tag, "/state"}, 32'(state_o), 32'(sb_e.st));
            if (sb_e.tag != "sat_fill" && sb_e.tag != "to_wait")
                $display("txn %-10s ctl=%b state=%0d stall=%0d flush=%0d err=%0b",
                         sb_e.tag, ctl_obs, state_o, stall_cnt_o, flush_cnt_o, mem_err_o);
        end
    end

    task automatic drv(input string tag, input logic rst_n,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] exrt,
                       input logic br, input logic ms, input logic md,
                       input logic req, input logic rdy,
                       input logic [7:0] exp_ctl, input logic [1:0] exp_st);
        sb_item_t it;
        @(posedge clk_i);
        #1;
        rst_i           = rst_n;
        IF_ID_Rs_i      = rs;
        IF_ID_Rt_i      = rt;
        ID_EX_MemRead_i = mr;
        ID_EX_Rt_i      = exrt;
        branch_taken_i  = br;
        mul_start_i     = ms;
        mul_done_i      = md;
        dmem_req_i      = req;
        dmem_ready_i    = rdy;
        it.tag = tag;
        it.ctl = exp_ctl;
        it.st  = exp_st;
        sb_q.push_back(it);
    endtask

    task automatic idle(input string tag);
        drv(tag, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, 2'd0);
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] stall, input logic [15:0] flush,
                           input logic err);
        @(negedge clk_i);
        check_eq({tag, "/stall_cnt"}, 32'(stall_cnt_o), 32'(stall));
        check_eq({tag, "/flush_cnt"}, 32'(flush_cnt_o), 32'(flush));
        check_eq({tag, "/mem_err"},   32'(mem_err_o),   32'(err));
    endtask

    initial begin
        rst_i = 1'b0;
        IF_ID_Rs_i = '0; IF_ID_Rt_i = '0; ID_EX_MemRead_i = 1'b0; ID_EX_Rt_i = '0;
        branch_taken_i = 1'b0; mul_start_i = 1'b0; mul_done_i = 1'b0;
        dmem_req_i = 1'b0; dmem_ready_i = 1'b0;

        // Reset: outputs stay at defaults even with every hazard input active.
        drv("rst_a", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, 2'd0);
        drv("rst_b", 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, E_DEF, 2'd0);
        chk_cnt("rst", 16'd0, 16'd0, 1'b0);
        idle("idle0");

        // Load-use hazards
        drv("lu_rs",     1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU,  2'd0);
        idle("lu_after");
        chk_cnt("lu", 16'd1, 16'd0, 1'b0);
        drv("lu_rt0",    1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, 2'd0);
        drv("lu_rt",     1'b1, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU,  2'd0);
        drv("lu_noload", 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, 2'd0);
        chk_cnt("lu2", 16'd2, 16'd0, 1'b0);

        // Taken branch overrides a simultaneous load-use and multiply
        drv("br", 1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_BR, 2'd0);
        idle("br_after");
        chk_cnt("br", 16'd2, 16'd1, 1'b0);

        // Memory wait: three not-ready cycles, branch ignored while frozen
        drv("mw0", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, 2'd0);
        drv("mw1", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, 2'd1);
        drv("mw2", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, 2'd1);
        drv("mw3", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_DEF, 2'd1);
        idle("mw_after");
        chk_cnt("mw", 16'd5, 16'd1, 1'b0);

        // Multiply: single-cycle op, then a 4-cycle op with a dmem stall in cycle 2
        drv("mul_1cyc", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_DEF, 2'd0);
        drv("mul0",     1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MH,  2'd0);
        drv("mul1",     1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MH,  2'd2);
        drv("mul_dmem", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_FRZ, 2'd2);
        drv("mul3",     1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MH,  2'd2);
        drv("mul_done", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_DEF, 2'd2);
        idle("mul_after");
        chk_cnt("mul", 16'd9, 16'd1, 1'b0);

        // Memory timeout: ready never arrives, forced release on the 64th cycle after entry
        drv("to_start", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, 2'd0);
        for (int k = 1; k < 64; k++)
            drv("to_wait", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ, 2'd1);
        drv("to_rel", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_DEF, 2'd1);
        chk_cnt("to_pre", 16'd73, 16'd1, 1'b0);
        idle("to_after");
        chk_cnt("to", 16'd73, 16'd1, 1'b1);

        // Sticky error survives normal traffic
        drv("post_lu", 1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, 2'd0);
        drv("post_br", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_BR, 2'd0);
        idle("post_idle");
        chk_cnt("post", 16'd74, 16'd2, 1'b1);

        // Saturation: a very long multiply stall drives stall_cnt past all-ones
        drv("sat_start", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MH, 2'd0);
        for (int k = 0; k < 65499; k++)
            drv("sat_fill", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MH, 2'd2);
        chk_cnt("sat", 16'hFFFF, 16'd2, 1'b1);
        for (int k = 0; k < 3; k++)
            drv("sat_hold", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MH, 2'd2);
        chk_cnt("sat_hold", 16'hFFFF, 16'd2, 1'b1);

        // Reset asserted mid-MUL_WAIT takes effect immediately
        drv("rst_mul", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_DEF, 2'd0);
        chk_cnt("rst_mul", 16'd0, 16'd0, 1'b0);
        drv("rst_rel", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF, 2'd0);
        idle("final");

        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
